// File: rtl/icevga_pkg.sv
// Shared constants and types for the icevga command controller.
package icevga_pkg;

  localparam int unsigned COLOR_W      = 12;
  localparam int unsigned POS_W        = 7;
  localparam int unsigned COLS_DEFAULT = 100;
  localparam int unsigned ROWS_DEFAULT = 75;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_SET_BG     = 8'h01;
  localparam logic [7:0] OP_SET_FG     = 8'h02;
  localparam logic [7:0] OP_SET_CURSOR = 8'h03;
  localparam logic [7:0] OP_PUT_CHAR   = 8'h04;

  typedef enum logic [1:0] {StOpc, StArg1, StArg2} dec_state_e;
  typedef enum logic [1:0] {StIdle, StStrobe, StRecover} rd_state_e;

  // Clamp an 8-bit coordinate argument to lim-1.
  function automatic logic [POS_W-1:0] sat_pos(input logic [7:0] v, input int unsigned lim);
    if ({24'd0, v} >= lim) return POS_W'(lim - 1);
    return v[POS_W-1:0];
  endfunction

endpackage

// File: rtl/icevga_cmd_ctrl_if.sv
// Character-write handshake between the command controller and the text-render stage.
interface icevga_cmd_ctrl_if;
  import icevga_pkg::*;

  logic             char_wr_valid;
  logic [7:0]       char_wr_code;
  logic [POS_W-1:0] char_wr_col;
  logic [POS_W-1:0] char_wr_row;
  logic             char_wr_ready;

  modport master (
    output char_wr_valid, char_wr_code, char_wr_col, char_wr_row,
    input  char_wr_ready
  );

  modport slave (
    input  char_wr_valid, char_wr_code, char_wr_col, char_wr_row,
    output char_wr_ready
  );
endinterface

// File: rtl/icevga_fifo_rd_seq.sv
// Synchronises the FIFO empty flag and paces active-low read strobes, capturing one byte per read.
module icevga_fifo_rd_seq
  import icevga_pkg::*;
#(
  parameter int unsigned RD_PULSE_CYCLES    = 4,
  parameter int unsigned RD_RECOVERY_CYCLES = 2,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       nef_in,
  input  logic [7:0] disp_cmd_in,
  input  logic       stall_i,
  output logic       disp_cmd_rd,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);

  // Recovery also covers the synchroniser so a fresh empty flag is seen before re-reading.
  localparam int unsigned RecoverCycles = RD_RECOVERY_CYCLES + SYNC_STAGES;
  localparam int unsigned CntMax = (RD_PULSE_CYCLES > RecoverCycles) ? RD_PULSE_CYCLES
                                                                     : RecoverCycles;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] PulseLast   = CntW'(RD_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] RecoverLast = CntW'(RecoverCycles - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   nef_s;
  rd_state_e              state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   rd_q, rd_d;
  logic [7:0]             byte_q, byte_d;
  logic                   valid_q, valid_d;

  always_comb begin
    sync_d[0] = nef_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  assign nef_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (nef_s && !stall_i && !valid_q) begin
          rd_d    = 1'b0;
          cnt_d   = PulseLast;
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          byte_d  = disp_cmd_in;
          valid_d = 1'b1;
          rd_d    = 1'b1;
          cnt_d   = RecoverLast;
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRecover: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q  <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_q    <= 1'b1;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign disp_cmd_rd  = rd_q;
  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;

endmodule

// File: rtl/icevga_cmd_ctrl.sv
// Parses the command FIFO byte stream into colour, cursor and character-write updates.
// Optional ICEVGA_VSYNC_APPLY_EN: colour writes are shadowed and applied after vblank_start.
module icevga_cmd_ctrl
  import icevga_pkg::*;
#(
  parameter int unsigned RD_PULSE_CYCLES    = 4,
  parameter int unsigned RD_RECOVERY_CYCLES = 2,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned COLS               = COLS_DEFAULT,
  parameter int unsigned ROWS               = ROWS_DEFAULT
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               nef_in,
  input  logic [7:0]         disp_cmd_in,
  output logic               disp_cmd_rd,
  input  logic               vblank_start,
  output logic [COLOR_W-1:0] bg_color,
  output logic [COLOR_W-1:0] fg_color,
  output logic [POS_W-1:0]   cursor_col,
  output logic [POS_W-1:0]   cursor_row,
  icevga_cmd_ctrl_if.master  char_wr,
  output logic               proto_err
);

  localparam logic [POS_W-1:0] ColLast = POS_W'(COLS - 1);
  localparam logic [POS_W-1:0] RowLast = POS_W'(ROWS - 1);

  logic               byte_valid;
  logic [7:0]         rx_byte;
  logic [COLOR_W-1:0] color_new;

  dec_state_e         dec_q, dec_d;
  logic [7:0]         op_q, op_d;
  logic [7:0]         arg1_q, arg1_d;
  logic [COLOR_W-1:0] bg_q, bg_d, fg_q, fg_d;
  logic [COLOR_W-1:0] bg_sh_q, bg_sh_d, fg_sh_q, fg_sh_d;
  logic [POS_W-1:0]   col_q, col_d, row_q, row_d;
  logic               wr_valid_q, wr_valid_d;
  logic [7:0]         wr_code_q, wr_code_d;
  logic [POS_W-1:0]   wr_col_q, wr_col_d, wr_row_q, wr_row_d;
  logic               proto_q, proto_d;

  icevga_fifo_rd_seq #(
    .RD_PULSE_CYCLES    (RD_PULSE_CYCLES),
    .RD_RECOVERY_CYCLES (RD_RECOVERY_CYCLES),
    .SYNC_STAGES        (SYNC_STAGES)
  ) u_rd_seq (
    .clk          (clk),
    .nrst         (nrst),
    .nef_in       (nef_in),
    .disp_cmd_in  (disp_cmd_in),
    .stall_i      (wr_valid_q),
    .disp_cmd_rd  (disp_cmd_rd),
    .byte_o       (rx_byte),
    .byte_valid_o (byte_valid)
  );

  assign color_new = {arg1_q[3:0], rx_byte};

  always_comb begin
    dec_d      = dec_q;
    op_d       = op_q;
    arg1_d     = arg1_q;
    bg_d       = bg_q;
    fg_d       = fg_q;
    bg_sh_d    = bg_sh_q;
    fg_sh_d    = fg_sh_q;
    col_d      = col_q;
    row_d      = row_q;
    wr_valid_d = wr_valid_q;
    wr_code_d  = wr_code_q;
    wr_col_d   = wr_col_q;
    wr_row_d   = wr_row_q;
    proto_d    = 1'b0;

    // Reads stall while a write is pending, so this never races a SET_CURSOR.
    if (wr_valid_q && char_wr.char_wr_ready) begin
      wr_valid_d = 1'b0;
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + POS_W'(1);
      end else begin
        col_d = col_q + POS_W'(1);
      end
    end

    if (byte_valid) begin
      unique case (dec_q)
        StOpc: begin
          case (rx_byte)
            OP_NOP: ;
            OP_SET_BG, OP_SET_FG, OP_SET_CURSOR, OP_PUT_CHAR: begin
              op_d  = rx_byte;
              dec_d = StArg1;
            end
            default: proto_d = 1'b1;
          endcase
        end
        StArg1: begin
          if (op_q == OP_PUT_CHAR) begin
            wr_valid_d = 1'b1;
            wr_code_d  = rx_byte;
            wr_col_d   = col_q;
            wr_row_d   = row_q;
            dec_d      = StOpc;
          end else begin
            arg1_d = rx_byte;
            dec_d  = StArg2;
          end
        end
        StArg2: begin
          dec_d = StOpc;
          case (op_q)
            OP_SET_BG: bg_sh_d = color_new;
            OP_SET_FG: fg_sh_d = color_new;
            OP_SET_CURSOR: begin
              col_d = sat_pos(arg1_q, COLS);
              row_d = sat_pos(rx_byte, ROWS);
            end
            default: ;
          endcase
        end
        default: dec_d = StOpc;
      endcase
    end

`ifdef ICEVGA_VSYNC_APPLY_EN
    // Shadow value as of this cycle; a write landing now waits for the next vblank.
    if (vblank_start) begin
      bg_d = bg_sh_q;
      fg_d = fg_sh_q;
    end
`else
    bg_d = bg_sh_d;
    fg_d = fg_sh_d;
`endif
  end

`ifndef ICEVGA_VSYNC_APPLY_EN
  logic unused_vblank;
  assign unused_vblank = vblank_start;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dec_q      <= StOpc;
      op_q       <= OP_NOP;
      arg1_q     <= '0;
      bg_q       <= 12'h000;
      fg_q       <= 12'hFFF;
      bg_sh_q    <= 12'h000;
      fg_sh_q    <= 12'hFFF;
      col_q      <= '0;
      row_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_code_q  <= '0;
      wr_col_q   <= '0;
      wr_row_q   <= '0;
      proto_q    <= 1'b0;
    end else begin
      dec_q      <= dec_d;
      op_q       <= op_d;
      arg1_q     <= arg1_d;
      bg_q       <= bg_d;
      fg_q       <= fg_d;
      bg_sh_q    <= bg_sh_d;
      fg_sh_q    <= fg_sh_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wr_valid_q <= wr_valid_d;
      wr_code_q  <= wr_code_d;
      wr_col_q   <= wr_col_d;
      wr_row_q   <= wr_row_d;
      proto_q    <= proto_d;
    end
  end

  assign bg_color              = bg_q;
  assign fg_color              = fg_q;
  assign cursor_col            = col_q;
  assign cursor_row            = row_q;
  assign char_wr.char_wr_valid = wr_valid_q;
  assign char_wr.char_wr_code  = wr_code_q;
  assign char_wr.char_wr_col   = wr_col_q;
  assign char_wr.char_wr_row   = wr_row_q;
  assign proto_err             = proto_q;

endmodule

// File: doc/icevga_cmd_ctrl.md
Name: icevga_cmd_ctrl

Overview:
Command controller between the external 8-bit command FIFO and the icevga pixel datapath. Drains the FIFO using its active-low empty flag and read strobe, and parses the byte stream into configuration updates: background colour, foreground colour and cursor. Character writes are issued over a valid/ready handshake to the text-render stage. Runs on the 120 MHz PLL clock.

Parameters:
RD_PULSE_CYCLES, 4, cycles disp_cmd_rd is held low per FIFO read (minimum 1)
RD_RECOVERY_CYCLES, 2, minimum high time of disp_cmd_rd between reads
SYNC_STAGES, 2, flop stages synchronising nef_in
COLS, 100, text columns (800/8)
ROWS, 75, text rows (600/8)

Ports:
clk  in  1  120 MHz global clock
nrst  in  1  reset; asynchronous assert, active-low
nef_in  in  1  FIFO empty flag, active-low (1 = data available), asynchronous
disp_cmd_in  in  8  FIFO data
disp_cmd_rd  out  1  FIFO read strobe, active-low
vblank_start  in  1  one-cycle pulse from timing generator at start of vertical blanking
bg_color  out  12  {R,G,B} 4 bits each
fg_color  out  12  {R,G,B}
cursor_col  out  7  current column
cursor_row  out  7  current row
char_wr_valid  out  1  character write request
char_wr_code  out  8  character code
char_wr_col  out  7  target column
char_wr_row  out  7  target row
char_wr_ready  in  1  render stage accepts
proto_err  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset values: disp_cmd_rd=1, bg_color=12'h000, fg_color=12'hFFF, cursor=(0,0), char_wr_valid=0, char_wr_code/col/row=0, proto_err=0; both FSMs idle; partial command discarded.
- Reset mid-read: disp_cmd_rd returns to 1 asynchronously; the byte being read is lost.
- nef_in passes through SYNC_STAGES flops to give nef_s. disp_cmd_in is not synchronised; it is sampled only on the last strobe cycle.
- Read FSM: IDLE, STROBE, RECOVER.
  - IDLE: if nef_s=1 and char_wr_valid=0 and no byte is pending, drive disp_cmd_rd<=0 and go to STROBE.
  - STROBE: disp_cmd_rd is held low for exactly RD_PULSE_CYCLES cycles. In the final cycle, register disp_cmd_in, drive disp_cmd_rd<=1, and go to RECOVER.
  - RECOVER: stay RD_RECOVERY_CYCLES+SYNC_STAGES cycles so the updated empty flag propagates before the next read, then return to IDLE.
  - Never strobe while nef_s=0.
- Latched byte is presented to the decoder as byte_valid one cycle after capture.
- Decoder FSM: OPC, ARG1, ARG2.
  - 0x01 SET_BG, 2 args: arg1[3:0]=R, arg2={G,B}.
  - 0x02 SET_FG, same format.
  - 0x03 SET_CURSOR: arg1=col, arg2=row; each saturates to COLS-1/ROWS-1.
  - 0x04 PUT_CHAR, 1 arg: raise char_wr_valid with code and current cursor.
  - 0x00 NOP: ignored.
  - Other opcodes: proto_err pulse, stay in OPC (byte dropped).
- Colour/cursor updates take effect the cycle after the final argument byte is decoded.
- char_wr handshake:
  - valid, code, col and row stay stable until valid & ready; valid deasserts the cycle after the handshake.
  - FIFO reads are stalled while valid=1.
  - The cursor advances on the handshake: col+1. At col=COLS-1: col=0, row+1. At (COLS-1, ROWS-1): wrap to (0,0).
- SET_CURSOR and a handshake can never coincide: reads stall during a pending write.

Optional Feature:
ICEVGA_VSYNC_APPLY_EN
- Defined: SET_BG/SET_FG write shadow registers. bg_color/fg_color update only on the cycle after vblank_start. Multiple writes in one frame: last wins. A write completing in the same cycle as vblank_start is applied at the next vblank.
- Undefined: colours update immediately as above; vblank_start is ignored.

Decomposition:
- Package icevga_pkg: opcode constants (OP_NOP, OP_SET_BG, OP_SET_FG, OP_SET_CURSOR, OP_PUT_CHAR), COLOR_W=12, default COLS/ROWS, decoder state enum.
- Sub-module icevga_fifo_rd_seq: synchroniser plus read FSM. Outputs byte/byte_valid; takes a stall input.
- Decoder, cursor and colour registers live in icevga_cmd_ctrl.

Test Plan:
- Reset, then nef_in=1 with bytes 01,0A,5C: disp_cmd_rd low for 4-cycle pulses, ≥4 cycles high between pulses; bg_color=12'hA5C, fg_color stays FFF.
- nef_in=0 throughout: disp_cmd_rd stays 1 indefinitely. Deassert nef_in after the first byte of a 3-byte command: exactly one read occurs and the decoder waits in ARG1.
- 03,05,02 then 04,41 with char_wr_ready=0 for 10 cycles: char_wr_valid held with code 0x41 at (5,2), no reads meanwhile. Raise ready: one handshake, cursor becomes (6,2).
- 03,FF,FF then 04,20: cursor saturates to (99,74); after the handshake cursor wraps to (0,0).
- Byte 0x7E then 02,0F,00: proto_err single pulse, fg_color=12'hF00.
- ICEVGA_VSYNC_APPLY_EN defined: 01,0F,FF then 01,00,01 before vblank_start: bg_color stays 000 until the cycle after vblank_start, then 12'h001.
